// File: rtl/cacheline_adapter.sv
// Bridges a single-cycle cache line port to a beat-serial memory bus:
// fills gather BEATS memory beats into a line, writebacks split a line into beats.
module cacheline_adapter #(
  parameter int s_line  = 256,
  parameter int s_burst = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [s_line-1:0]   line_i,
  output logic [s_line-1:0]   line_o,
  input  logic [31:0]         address_i,
  input  logic                read_i,
  input  logic                write_i,
  output logic                resp_o,
  input  logic [s_burst-1:0]  burst_i,
  output logic [s_burst-1:0]  burst_o,
  output logic [31:0]         address_o,
  output logic                read_o,
  output logic                write_o,
  input  logic                resp_i
);

  localparam int BEATS = s_line / s_burst;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [CNT_W-1:0]    r_cnt;
  logic [31:0]         r_addr;
  logic [s_line-1:0]   r_line_buf;
  logic [s_line-1:0]   r_wbuf;
  logic                w_last;

  assign w_last = (r_cnt == CNT_W'(BEATS - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; a read wins over a simultaneous write, which stays pending
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (read_i) begin
          w_next = ST_READ;
        end else if (write_i) begin
          w_next = ST_WRITE;
        end
      end
      ST_READ: begin
        if (resp_i && w_last) begin
          w_next = ST_DONE;
        end
      end
      ST_WRITE: begin
        if (resp_i && w_last) begin
          w_next = ST_DONE;
        end
      end
      ST_DONE: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Beat counter, latched request and line buffers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_addr     <= '0;
      r_line_buf <= '0;
      r_wbuf     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (read_i) begin
            r_addr <= address_i;
            r_cnt  <= '0;
          end else if (write_i) begin
            r_addr <= address_i;
            r_wbuf <= line_i;
            r_cnt  <= '0;
          end
        end
        ST_READ: begin
          if (resp_i) begin
            for (int k = 0; k < BEATS; k++) begin
              if (r_cnt == CNT_W'(k)) begin
                r_line_buf[k*s_burst +: s_burst] <= burst_i;
              end
            end
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_WRITE: begin
          if (resp_i) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Outputs are pure decodes of registered state; no request-to-bus path
  always_comb begin
    read_o    = (r_state == ST_READ);
    write_o   = (r_state == ST_WRITE);
    resp_o    = (r_state == ST_DONE);
    address_o = r_addr;
    line_o    = r_line_buf;
    burst_o   = r_wbuf[s_burst-1:0];
    for (int k = 0; k < BEATS; k++) begin
      if (r_cnt == CNT_W'(k)) begin
        burst_o = r_wbuf[k*s_burst +: s_burst];
      end
    end
  end

endmodule

// File: tb/tb_cacheline_adapter.sv
// Self-checking bench for cacheline_adapter: transaction-level reference model
// compared every cycle, plus directed scenarios with hand-computed expectations.
module tb_cacheline_adapter;

  localparam int S_LINE  = 256;
  localparam int S_BURST = 64;
  localparam int BEATS   = S_LINE / S_BURST;

  logic               clk = 1'b0;
  logic               rst;
  logic [S_LINE-1:0]  line_i;
  logic [S_LINE-1:0]  line_o;
  logic [31:0]        address_i;
  logic               read_i;
  logic               write_i;
  logic               resp_o;
  logic [S_BURST-1:0] burst_i;
  logic [S_BURST-1:0] burst_o;
  logic [31:0]        address_o;
  logic               read_o;
  logic               write_o;
  logic               resp_i;

  cacheline_adapter #(.s_line(S_LINE), .s_burst(S_BURST)) dut (
    .clk(clk), .rst(rst),
    .line_i(line_i), .line_o(line_o),
    .address_i(address_i), .read_i(read_i), .write_i(write_i), .resp_o(resp_o),
    .burst_i(burst_i), .burst_o(burst_o),
    .address_o(address_o), .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;
  bit mem_rand = 1'b0;

  // Reference model: which transaction is in flight, how many beats are done,
  // whether a completion is owed, and the line contents as arrays of words.
  int           m_kind  = 0;   // 0 none, 1 fill, 2 writeback
  int           m_beats = 0;
  bit           m_resp  = 1'b0;
  logic [31:0]  m_addr  = '0;
  logic [63:0]  m_line [BEATS];
  logic [63:0]  m_wb   [BEATS];

  function automatic logic [63:0] rep(input logic [3:0] n);
    return {16{n}};
  endfunction

  function automatic logic [S_LINE-1:0] rnd_line();
    logic [S_LINE-1:0] v;
    for (int k = 0; k < S_LINE/32; k++) v[k*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic chk(input string nm, input logic [S_LINE-1:0] act, input logic [S_LINE-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial begin
    for (int k = 0; k < BEATS; k++) begin
      m_line[k] = '0;
      m_wb[k]   = '0;
    end
    forever begin
      @(posedge clk);
      if (rst) begin
        m_kind = 0; m_beats = 0; m_resp = 1'b0; m_addr = '0;
        for (int k = 0; k < BEATS; k++) begin
          m_line[k] = '0;
          m_wb[k]   = '0;
        end
      end else if (m_resp) begin
        m_resp = 1'b0;
      end else if (m_kind == 0) begin
        if (read_i) begin
          m_kind = 1; m_beats = 0; m_addr = address_i;
        end else if (write_i) begin
          m_kind = 2; m_beats = 0; m_addr = address_i;
          for (int k = 0; k < BEATS; k++) m_wb[k] = line_i[k*S_BURST +: S_BURST];
        end
      end else if (resp_i) begin
        if (m_kind == 1) m_line[m_beats] = burst_i;
        if (m_beats == BEATS - 1) begin
          m_kind = 0; m_beats = 0; m_resp = 1'b1;
        end else begin
          m_beats++;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  initial begin
    logic [S_LINE-1:0] el;
    bit prev_resp;
    prev_resp = 1'b0;
    forever begin
      @(negedge clk);
      if (chk_on) begin
        for (int k = 0; k < BEATS; k++) el[k*S_BURST +: S_BURST] = m_line[k];
        chk("read_o",    S_LINE'(read_o),    S_LINE'(m_kind == 1));
        chk("write_o",   S_LINE'(write_o),   S_LINE'(m_kind == 2));
        chk("resp_o",    S_LINE'(resp_o),    S_LINE'(m_resp));
        chk("address_o", S_LINE'(address_o), S_LINE'(m_addr));
        chk("line_o",    line_o,             el);
        if (m_kind == 2) chk("burst_o", S_LINE'(burst_o), S_LINE'(m_wb[m_beats]));
        if (prev_resp) chk("resp_o_not_back_to_back", S_LINE'(resp_o), S_LINE'(0));
        prev_resp = resp_o;
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
    if (mem_rand) begin
      resp_i  = ($urandom_range(0, 3) != 0);
      burst_i = {$urandom(), $urandom()};
    end
  endtask

  // Fill with burst_i = rep(n) in cycle n after acceptance; pat bit n-1 gives resp_i
  task automatic dir_read(input logic [31:0] a, input logic [15:0] pat, input bit tail,
                          output int resp_at);
    resp_at = -1;
    read_i = 1'b1; write_i = 1'b0; address_i = a; resp_i = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      cycle();
      if (read_o) chk("rd_address_o", S_LINE'(address_o), S_LINE'(a));
      if (resp_o) begin
        resp_at = n;
        break;
      end
      resp_i  = (n <= 16) ? pat[n-1] : 1'b0;
      burst_i = rep(4'(n));
    end
    resp_i = 1'b0;
    if (tail) begin
      for (int j = 0; j < 3; j++) begin
        cycle();
        read_i = 1'b0;
        chk("no_dup_read_o", S_LINE'(read_o), S_LINE'(0));
        chk("no_dup_resp_o", S_LINE'(resp_o), S_LINE'(0));
      end
    end
  endtask

  task automatic rand_req(input int kind);
    int  need, got, n;
    bit  drop_r;
    need = (kind == 2) ? 2 : 1;
    got = 0; n = 0; drop_r = 1'b0;
    read_i    = (kind != 1);
    write_i   = (kind != 0);
    address_i = $urandom() & 32'hFFFF_FFE0;
    line_i    = rnd_line();
    while (1) begin
      cycle();
      n++;
      if (got == need) begin
        read_i = 1'b0; write_i = 1'b0;
        break;
      end
      if (drop_r) begin
        read_i = 1'b0; drop_r = 1'b0;
      end
      address_i = $urandom() & 32'hFFFF_FFE0;
      line_i    = rnd_line();
      if (resp_o) begin
        got++;
        if (need == 2 && got == 1) drop_r = 1'b1;
      end
      if (n > 400) begin
        chk("rand_req_timeout", S_LINE'(got), S_LINE'(need));
        read_i = 1'b0; write_i = 1'b0;
        break;
      end
    end
  endtask

  initial begin
    logic [S_LINE-1:0] lw, lsim;
    int ra, r1, r2, fr, fw, np, k, rdcnt;
    bit drop;

    rst = 1'b1; read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
    address_i = '0; line_i = '0; burst_i = '0;
    cycle();
    chk_on = 1'b1;
    cycle();
    chk("rst_read_o",    S_LINE'(read_o),    S_LINE'(0));
    chk("rst_write_o",   S_LINE'(write_o),   S_LINE'(0));
    chk("rst_resp_o",    S_LINE'(resp_o),    S_LINE'(0));
    chk("rst_line_o",    line_o,             S_LINE'(0));
    chk("rst_address_o", S_LINE'(address_o), S_LINE'(0));
    rst = 1'b0;
    cycle();

    // Read fill, beats every cycle
    dir_read(32'h0000_1A40, 16'h000F, 1'b1, ra);
    chk("fill_resp_cycle", S_LINE'(ra), S_LINE'(5));
    chk("fill_line_o", line_o, {rep(4'h4), rep(4'h3), rep(4'h2), rep(4'h1)});

    // Writeback; line_i and address_i scrambled after acceptance
    lw = {rep(4'hD), rep(4'hC), rep(4'hB), rep(4'hA)};
    line_i = lw; address_i = 32'h0000_7C20; write_i = 1'b1; resp_i = 1'b0;
    k = 0; ra = -1;
    for (int n = 1; n <= 12; n++) begin
      cycle();
      line_i = rnd_line();
      address_i = $urandom() & 32'hFFFF_FFE0;
      if (write_o) begin
        chk("wb_address_o", S_LINE'(address_o), S_LINE'(32'h0000_7C20));
        if (k < 4) chk("wb_burst_o", S_LINE'(burst_o), S_LINE'(rep(4'(10 + k))));
        k++;
      end
      if (resp_o) begin
        chk("wb_write_o_in_resp", S_LINE'(write_o), S_LINE'(0));
        ra = n;
        break;
      end
      resp_i = 1'b1;
    end
    cycle();
    write_i = 1'b0; resp_i = 1'b0;
    chk("wb_beat_count", S_LINE'(k), S_LINE'(4));
    chk("wb_resp_cycle", S_LINE'(ra), S_LINE'(5));

    // Stalled beats: resp_i = 1,0,0,1,0,1,1
    dir_read(32'h0000_0C80, 16'h0069, 1'b1, ra);
    chk("stall_resp_cycle", S_LINE'(ra), S_LINE'(8));
    chk("stall_line_o", line_o, {rep(4'h7), rep(4'h6), rep(4'h4), rep(4'h1)});

    // Simultaneous read and write: read first, then the pending write
    lsim = rnd_line();
    read_i = 1'b1; write_i = 1'b1; address_i = 32'h0000_4A00; line_i = lsim; resp_i = 1'b1;
    r1 = -1; r2 = -1; fr = -1; fw = -1; np = 0; drop = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      cycle();
      if (drop) begin
        if (np == 1) read_i = 1'b0;
        else write_i = 1'b0;
        drop = 1'b0;
      end
      burst_i = {$urandom(), $urandom()};
      if (read_o && fr < 0) fr = n;
      if (write_o && fw < 0) fw = n;
      if (resp_o) begin
        np++;
        if (np == 1) r1 = n;
        else if (np == 2) r2 = n;
        drop = 1'b1;
      end
    end
    resp_i = 1'b0;
    chk("sim_resp_pulses", S_LINE'(np), S_LINE'(2));
    chk("sim_first_read",  S_LINE'(fr), S_LINE'(1));
    chk("sim_first_write", S_LINE'(fw), S_LINE'(7));
    chk("sim_resp1_cycle", S_LINE'(r1), S_LINE'(5));
    chk("sim_resp2_cycle", S_LINE'(r2), S_LINE'(11));

    // Reset after two accepted beats
    read_i = 1'b1; address_i = 32'h0000_2000; resp_i = 1'b0;
    for (int n = 1; n <= 2; n++) begin
      cycle();
      resp_i = 1'b1; burst_i = rep(4'(n + 4));
    end
    cycle();
    rst = 1'b1; read_i = 1'b0; resp_i = 1'b0;
    cycle();
    chk("mid_rst_read_o",    S_LINE'(read_o),    S_LINE'(0));
    chk("mid_rst_resp_o",    S_LINE'(resp_o),    S_LINE'(0));
    chk("mid_rst_line_o",    line_o,             S_LINE'(0));
    chk("mid_rst_address_o", S_LINE'(address_o), S_LINE'(0));
    rst = 1'b0;
    cycle();
    dir_read(32'h0000_3000, 16'h000F, 1'b1, ra);
    chk("post_rst_resp_cycle", S_LINE'(ra), S_LINE'(5));
    chk("post_rst_line_o", line_o, {rep(4'h4), rep(4'h3), rep(4'h2), rep(4'h1)});

    // Back-to-back: write issued in the cycle after the read's resp_o
    dir_read(32'h0000_5540, 16'h000F, 1'b0, ra);
    chk("b2b_read_resp_cycle", S_LINE'(ra), S_LINE'(5));
    cycle();
    read_i = 1'b0; write_i = 1'b1; address_i = 32'h0000_9EE0; line_i = rnd_line(); resp_i = 1'b1;
    fw = -1; rdcnt = 0; ra = -1;
    for (int m = 1; m <= 12; m++) begin
      cycle();
      if (read_o) rdcnt++;
      if (write_o && fw < 0) begin
        fw = m;
        chk("b2b_address_o", S_LINE'(address_o), S_LINE'(32'h0000_9EE0));
      end
      if (resp_o) begin
        ra = m;
        break;
      end
    end
    cycle();
    write_i = 1'b0; resp_i = 1'b0;
    chk("b2b_no_dup_read", S_LINE'(rdcnt), S_LINE'(0));
    chk("b2b_write_start", S_LINE'(fw), S_LINE'(1));
    chk("b2b_write_resp",  S_LINE'(ra), S_LINE'(5));

    // Randomized traffic checked by the model
    mem_rand = 1'b1;
    for (int t = 0; t < 150; t++) begin
      rand_req($urandom_range(0, 2));
      repeat ($urandom_range(0, 2)) cycle();
    end
    mem_rand = 1'b0;
    resp_i = 1'b0;
    repeat (3) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
